// File: rtl/jt900h_bus_arb.sv
// Fetch/data arbiter for the 16-bit external bus; data accesses are split into little-endian beats.
// Starvation guard forces a fetch grant after STARVE back-to-back data grants while f_req is pending.
module jt900h_bus_arb #(
    parameter int AW     = 24,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_din,
    output logic [31:0]   d_dout,
    output logic          d_ack,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic [15:0]   f_dout,
    output logic          f_ack,
    output logic [AW-2:0] bus_addr,
    output logic [15:0]   bus_dout,
    input  logic [15:0]   bus_din,
    output logic          bus_rd,
    output logic [1:0]    bus_we,
    input  logic          bus_ok
);

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    localparam logic [2:0] STARVE_C = 3'(STARVE);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          we_q, we_d, odd_q, odd_d;
    logic [1:0]    size_q, size_d, beat_q, beat_d;
    logic [47:0]   wbuf_q, wbuf_d, rbuf_q, rbuf_d;
    logic [AW-2:0] addr_q, addr_d;
    logic [31:0]   d_dout_q, d_dout_d;
    logic [15:0]   f_dout_q, f_dout_d, bdout_q, bdout_d;
    logic          d_ack_q, d_ack_d, f_ack_q, f_ack_d, rd_q, rd_d;
    logic [1:0]    bwe_q, bwe_d;
    logic [2:0]    last_byte;
    logic [31:0]   full;
    logic [18:0]   strb;
    logic          unused_f_addr0;

    assign unused_f_addr0 = f_addr[0];

    // Byte positions relative to the even word base: the access spans [odd, last].
    function automatic logic [2:0] last_pos(input logic odd, input logic [1:0] size);
        return {2'b00, odd} + ((size == 2'd0) ? 3'd0 : (size == 2'd1) ? 3'd1 : 3'd3);
    endfunction

    // Returns {rd, we[1:0], dout[15:0]} for one beat; lanes outside the access are zeroed.
    function automatic logic [18:0] beat_strb(input logic we, input logic odd, input logic [1:0] size,
                                              input logic [1:0] beat, input logic [47:0] wbuf);
        logic [2:0]  lo, hi, first, last;
        logic [1:0]  lanes;
        logic [15:0] w;
        first    = {2'b00, odd};
        last     = last_pos(odd, size);
        lo       = {beat, 1'b0};
        hi       = lo + 3'd1;
        lanes[0] = (lo >= first) && (lo <= last);
        lanes[1] = (hi >= first) && (hi <= last);
        w        = wbuf[{beat, 4'b0000} +: 16];
        if (we) return {1'b0, lanes, (lanes[1] ? w[15:8] : 8'h00), (lanes[0] ? w[7:0] : 8'h00)};
        return {1'b1, 2'b00, 16'h0000};
    endfunction

    assign last_byte = last_pos(odd_q, size_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        odd_d    = odd_q;
        size_d   = size_q;
        beat_d   = beat_q;
        wbuf_d   = wbuf_q;
        rbuf_d   = rbuf_q;
        addr_d   = addr_q;
        d_dout_d = d_dout_q;
        f_dout_d = f_dout_q;
        bdout_d  = bdout_q;
        rd_d     = rd_q;
        bwe_d    = bwe_q;
        d_ack_d  = 1'b0;
        f_ack_d  = 1'b0;
        strb     = 19'h0;
        full     = 32'h0;
        case (state_q)
            IDLE: begin
                if (d_req && (!f_req || cnt_q < STARVE_C)) begin
                    state_d = DATA;
                    cnt_d   = f_req ? ((cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1) : 3'd0;
                    we_d    = d_we;
                    odd_d   = d_addr[0];
                    size_d  = d_size;
                    beat_d  = 2'd0;
                    wbuf_d  = d_addr[0] ? {8'h00, d_din, 8'h00} : {16'h0000, d_din};
                    rbuf_d  = 48'h0;
                    addr_d  = d_addr[AW-1:1];
                    strb    = beat_strb(d_we, d_addr[0], d_size, 2'd0, wbuf_d);
                    rd_d    = strb[18];
                    bwe_d   = strb[17:16];
                    bdout_d = strb[15:0];
                end else if (f_req) begin
                    state_d = FETCH;
                    cnt_d   = 3'd0;
                    addr_d  = f_addr[AW-1:1];
                    rd_d    = 1'b1;
                    bwe_d   = 2'b00;
                    bdout_d = 16'h0000;
                end
            end
            DATA: begin
                if (bus_ok) begin
                    if (!we_q) rbuf_d[{beat_q, 4'b0000} +: 16] = bus_din;
                    if (beat_q == last_byte[2:1]) begin
                        state_d = IDLE;
                        rd_d    = 1'b0;
                        bwe_d   = 2'b00;
                        bdout_d = 16'h0000;
                        d_ack_d = 1'b1;
                        full    = odd_q ? rbuf_d[39:8] : rbuf_d[31:0];
                        if (!we_q) begin
                            case (size_q)
                                2'd0:    d_dout_d = {24'h0, full[7:0]};
                                2'd1:    d_dout_d = {16'h0, full[15:0]};
                                default: d_dout_d = full;
                            endcase
                        end
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        addr_d  = addr_q + 1'b1;
                        strb    = beat_strb(we_q, odd_q, size_q, beat_d, wbuf_q);
                        rd_d    = strb[18];
                        bwe_d   = strb[17:16];
                        bdout_d = strb[15:0];
                    end
                end
            end
            FETCH: begin
                if (bus_ok) begin
                    state_d  = IDLE;
                    f_dout_d = bus_din;
                    f_ack_d  = 1'b1;
                    rd_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            we_q     <= 1'b0;
            odd_q    <= 1'b0;
            size_q   <= 2'd0;
            beat_q   <= 2'd0;
            wbuf_q   <= 48'h0;
            rbuf_q   <= 48'h0;
            addr_q   <= '0;
            d_dout_q <= 32'h0;
            f_dout_q <= 16'h0;
            bdout_q  <= 16'h0;
            rd_q     <= 1'b0;
            bwe_q    <= 2'b00;
            d_ack_q  <= 1'b0;
            f_ack_q  <= 1'b0;
        end else if (cen) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            odd_q    <= odd_d;
            size_q   <= size_d;
            beat_q   <= beat_d;
            wbuf_q   <= wbuf_d;
            rbuf_q   <= rbuf_d;
            addr_q   <= addr_d;
            d_dout_q <= d_dout_d;
            f_dout_q <= f_dout_d;
            bdout_q  <= bdout_d;
            rd_q     <= rd_d;
            bwe_q    <= bwe_d;
            d_ack_q  <= d_ack_d;
            f_ack_q  <= f_ack_d;
        end
    end

    assign d_dout   = d_dout_q;
    assign d_ack    = d_ack_q;
    assign f_dout   = f_dout_q;
    assign f_ack    = f_ack_q;
    assign bus_addr = addr_q;
    assign bus_dout = bdout_q;
    assign bus_rd   = rd_q;
    assign bus_we   = bwe_q;

endmodule

// File: tb/tb_jt900h_bus_arb.sv
// Scoreboard bench for jt900h_bus_arb: expected beats/acks queued by stimulus, checked by a monitor.
module tb_jt900h_bus_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [1:0]  d_size = 2'd0;
    logic [23:0] d_addr = 24'h0;
    logic [31:0] d_din = 32'h0;
    logic [31:0] d_dout;
    logic        d_ack;
    logic        f_req = 1'b0;
    logic [23:0] f_addr = 24'h0;
    logic [15:0] f_dout;
    logic        f_ack;
    logic [22:0] bus_addr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din = 16'h0;
    logic        bus_rd;
    logic [1:0]  bus_we;
    logic        bus_ok = 1'b0;

    jt900h_bus_arb #(.AW(24), .STARVE(4)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_din(d_din),
        .d_dout(d_dout), .d_ack(d_ack),
        .f_req(f_req), .f_addr(f_addr), .f_dout(f_dout), .f_ack(f_ack),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
        .bus_rd(bus_rd), .bus_we(bus_we), .bus_ok(bus_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 beat, 1 d_ack, 2 f_ack
        logic [47:0] val;
        bit          chk;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ws = 0;
    int          wcnt = 0;
    logic        prev_ok;
    logic [15:0] mem [logic [22:0]];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] mkb(input logic [22:0] wa, input logic rd,
                                         input logic [1:0] we, input logic [15:0] d);
        return {6'h0, wa, rd, we, d};
    endfunction

    task automatic push(input int kind, input logic [47:0] val, input bit c);
        exp_t e;
        e.kind = kind; e.val = val; e.chk = c;
        exp_q.push_back(e);
    endtask

    // Bus slave: read data from mem, ws wait cycles per beat
    always @(posedge clk) begin
        prev_ok = bus_ok;
        #1;
        if (rst || !(bus_rd || bus_we != 2'b00)) begin
            wcnt = 0; bus_ok = 1'b0; bus_din = 16'h0;
        end else begin
            if (prev_ok) wcnt = 0;
            bus_ok  = (wcnt >= ws);
            wcnt++;
            bus_din = (bus_rd && mem.exists(bus_addr)) ? mem[bus_addr] : 16'h0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_rd || bus_we != 2'b00) begin
                chk("rd_we_exclusive", {47'h0, bus_rd && (bus_we != 2'b00)}, 48'h0);
                if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got addr %h rd %b we %b at %0t", bus_addr, bus_rd, bus_we, $time);
                end else begin
                    chk("beat", mkb(bus_addr, bus_rd, bus_we, bus_dout), exp_q[0].val);
                    if (bus_ok) void'(exp_q.pop_front());
                end
            end
            if (d_ack) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
                    checks++; errors++;
                    $display("FAIL unexpected_d_ack: got d_dout %h at %0t", d_dout, $time);
                end else begin
                    if (exp_q[0].chk) chk("d_dout", {16'h0, d_dout}, exp_q[0].val);
                    void'(exp_q.pop_front());
                end
            end
            if (f_ack) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 2) begin
                    checks++; errors++;
                    $display("FAIL unexpected_f_ack: got f_dout %h at %0t", f_dout, $time);
                end else begin
                    chk("f_dout", {32'h0, f_dout}, exp_q[0].val);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic data_access(input logic we, input logic [1:0] size,
                               input logic [23:0] addr, input logic [31:0] din);
        bit got;
        got = 0;
        @(posedge clk); #2;
        d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_din = din;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #2;
            if (d_ack) begin got = 1; break; end
        end
        d_req = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL d_ack_timeout: got no ack expected ack for addr %h", addr);
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_bus"}, {6'h0, bus_addr, bus_rd, bus_we, bus_dout}, 48'h0);
        chk({nm, "_d"}, {15'h0, d_ack, d_dout}, 48'h0);
        chk({nm, "_f"}, {31'h0, f_ack, f_dout}, 48'h0);
    endtask

    initial begin
        int acks;
        bit hit;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Aligned long read
        mem[23'h80] = 16'h3412; mem[23'h81] = 16'h7856;
        push(0, mkb(23'h80, 1'b1, 2'b00, 16'h0), 1);
        push(0, mkb(23'h81, 1'b1, 2'b00, 16'h0), 1);
        push(1, 48'h78563412, 1);
        data_access(1'b0, 2'd2, 24'h000100, 32'h0);

        // Odd word write
        push(0, mkb(23'h100, 1'b0, 2'b10, 16'hAA00), 1);
        push(0, mkb(23'h101, 1'b0, 2'b01, 16'h00BB), 1);
        push(1, 48'h0, 0);
        data_access(1'b1, 2'd1, 24'h000201, 32'h0000BBAA);

        // Odd long read with two wait cycles per beat
        ws = 2;
        mem[23'h1] = 16'h11AA; mem[23'h2] = 16'h3322; mem[23'h3] = 16'h0044;
        push(0, mkb(23'h1, 1'b1, 2'b00, 16'h0), 1);
        push(0, mkb(23'h2, 1'b1, 2'b00, 16'h0), 1);
        push(0, mkb(23'h3, 1'b1, 2'b00, 16'h0), 1);
        push(1, 48'h44332211, 1);
        data_access(1'b0, 2'd2, 24'h000003, 32'h0);
        ws = 0;

        // Byte read from the odd lane
        mem[23'h2] = 16'hCD00;
        push(0, mkb(23'h2, 1'b1, 2'b00, 16'h0), 1);
        push(1, 48'h000000CD, 1);
        data_access(1'b0, 2'd0, 24'h000005, 32'h0);

        // Aligned word write, even byte write, odd long write
        push(0, mkb(23'h8, 1'b0, 2'b11, 16'h5678), 1);
        push(1, 48'h0, 0);
        data_access(1'b1, 2'd1, 24'h000010, 32'h12345678);
        push(0, mkb(23'h10, 1'b0, 2'b01, 16'h0099), 1);
        push(1, 48'h0, 0);
        data_access(1'b1, 2'd0, 24'h000020, 32'hFFFFFF99);
        push(0, mkb(23'h3, 1'b0, 2'b10, 16'hAA00), 1);
        push(0, mkb(23'h4, 1'b0, 2'b11, 16'hCCBB), 1);
        push(0, mkb(23'h5, 1'b0, 2'b01, 16'h00DD), 1);
        push(1, 48'h0, 0);
        data_access(1'b1, 2'd2, 24'h000007, 32'hDDCCBBAA);

        // Odd long read wrapping past the top of the address space
        mem[23'h7FFFFF] = 16'h5500; mem[23'h0] = 16'h7766;
        push(0, mkb(23'h7FFFFF, 1'b1, 2'b00, 16'h0), 1);
        push(0, mkb(23'h0, 1'b1, 2'b00, 16'h0), 1);
        push(0, mkb(23'h1, 1'b1, 2'b00, 16'h0), 1);
        push(1, 48'hAA776655, 1);
        data_access(1'b0, 2'd2, 24'hFFFFFF, 32'h0);

        // Continuous data and fetch requests: D,D,D,D,F twice
        mem[23'h20] = 16'hF00D;
        for (int g = 0; g < 10; g++) begin
            if (g % 5 == 4) begin
                push(0, mkb(23'h20, 1'b1, 2'b00, 16'h0), 1);
                push(2, 48'hF00D, 1);
            end else begin
                push(0, mkb(23'h2, 1'b1, 2'b00, 16'h0), 1);
                push(1, 48'hCD00, 1);
            end
        end
        @(posedge clk); #2;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd1; d_addr = 24'h000004;
        f_req = 1'b1; f_addr = 24'h000041;
        acks = 0;
        for (int i = 0; i < 200 && acks < 10; i++) begin
            @(posedge clk); #2;
            if (d_ack || f_ack) acks++;
        end
        d_req = 1'b0; f_req = 1'b0;
        chk("starve_ack_count", 48'(acks), 48'd10);

        // Reset during beat 2 of a long write
        ws = 3;
        push(0, mkb(23'h20, 1'b0, 2'b11, 16'h5678), 1);
        @(posedge clk); #2;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 24'h000040; d_din = 32'h12345678;
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (bus_addr == 23'h21 && bus_we != 2'b00) begin hit = 1; break; end
        end
        chk("reached_beat2", {47'h0, hit}, 48'h1);
        #1 rst = 1'b1;
        #1 check_all_zero("midreset");
        d_req = 1'b0;
        ws = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Fresh request after reset
        push(0, mkb(23'h2, 1'b1, 2'b00, 16'h0), 1);
        push(1, 48'h000000CD, 1);
        data_access(1'b0, 2'd0, 24'h000005, 32'h0);

        repeat (4) @(posedge clk);
        chk("queue_drained", 48'(exp_q.size()), 48'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
